// File: rtl/lease_table_loader.sv
// lease_table_loader
//
// Fetches one phase's lease table from memory and streams it into the lease
// lookup table's write port. On start_i a header word holding the reference
// count is read. The ref-address array and the lease array are then fetched
// one word at a time over a single-outstanding req/ack port. Each fetched word
// becomes one table write, and done_o pulses when the refresh is finished.
//
// Memory layout relative to the word-aligned base address:
//   +0            header (reference count R)
//   +4+4i         ref[i]
//   +4+4N+4i      lease[i]
//
// Ports:
//   clock_i, reset_i   clock, asynchronous active-high reset
//   start_i            begin a load (sampled only when idle)
//   base_addr_i        header byte address (low two bits ignored)
//   busy_o, done_o     load in progress / one-cycle completion pulse
//   mem_req_o          read request
//   mem_addr_o         read byte address
//   mem_ack_i          read acknowledge
//   mem_data_i         read data, valid with the acknowledge
//   tbl_addr_o         {array select (1 = lease), entry index}
//   tbl_wren_o         table write strobe
//   tbl_data_o         table write data
//   tbl_phase_refs_o   min(R, N_ENTRIES-1)
//
// Optional feature macro: LEASE_LOADER_SPARSE_FETCH_EN
//   When defined, ref entries at or beyond the reference count are written as
//   zero without a memory read. Lease entries in that range are skipped
//   entirely.

module lease_table_loader #(
  parameter int N_ENTRIES   = 128,
  parameter int BW_MEM_ADDR = 32,
  localparam int BW_ENTRIES = $clog2(N_ENTRIES)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [BW_MEM_ADDR-1:0] base_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_req_o,
  output logic [BW_MEM_ADDR-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [31:0]            mem_data_i,
  output logic [BW_ENTRIES:0]    tbl_addr_o,
  output logic                   tbl_wren_o,
  output logic [31:0]            tbl_data_o,
  output logic [BW_ENTRIES-1:0]  tbl_phase_refs_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [BW_ENTRIES-1:0] LAST_IDX = BW_ENTRIES'(N_ENTRIES - 1);

  logic [2:0]             state;
  logic [BW_MEM_ADDR-1:0] base;
  logic                   sel;       // 0: ref array, 1: lease array
  logic [BW_ENTRIES-1:0]  idx;
  logic [31:0]            data_q;
  logic [BW_ENTRIES-1:0]  phase_refs;

  logic                   nxt_sel;
  logic [BW_ENTRIES-1:0]  nxt_idx;
  logic                   last_item;
  logic [BW_ENTRIES-1:0]  hdr_refs;

  // The count saturates at N-1 so it always fits the entry index width.
  function automatic logic [BW_ENTRIES-1:0] clamp_refs(input logic [31:0] r);
    if (r >= 32'(N_ENTRIES - 1)) return LAST_IDX;
    return r[BW_ENTRIES-1:0];
  endfunction

  // The index wraps to 0 after ref[N-1] while the select bit sets, so the
  // item after the last ref is lease[0].
  always_comb begin
    nxt_sel   = sel | (idx == LAST_IDX);
    nxt_idx   = idx + 1'b1;
    last_item = sel && (idx == LAST_IDX);
    hdr_refs  = clamp_refs(mem_data_i);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      base       <= '0;
      sel        <= 1'b0;
      idx        <= '0;
      data_q     <= '0;
      phase_refs <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            base  <= {base_addr_i[BW_MEM_ADDR-1:2], 2'b00};
            sel   <= 1'b0;
            idx   <= '0;
            state <= S_HDR;
          end
        end
        S_HDR: begin
          if (mem_ack_i) begin
            phase_refs <= hdr_refs;
`ifdef LEASE_LOADER_SPARSE_FETCH_EN
            if (hdr_refs == '0) begin
              data_q <= '0;
              state  <= S_WR;
            end else begin
              state <= S_REQ;
            end
`else
            state <= S_REQ;
`endif
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            data_q <= mem_data_i;
            state  <= S_WR;
          end
        end
        S_WR: begin
          sel <= nxt_sel;
          idx <= nxt_idx;
          if (last_item) begin
            state <= S_DONE;
          end
`ifdef LEASE_LOADER_SPARSE_FETCH_EN
          // Unused ref entries are still written (as zero) to clear stale
          // valid bits; unused lease entries end the load early.
          else if (!nxt_sel && (nxt_idx >= phase_refs)) begin
            data_q <= '0;
            state  <= S_WR;
          end else if (nxt_sel && (nxt_idx >= phase_refs)) begin
            state <= S_DONE;
          end
`endif
          else begin
            state <= S_REQ;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from the state so an asynchronous reset drops the
  // request within the same cycle.
  always_comb begin
    mem_addr_o = '0;
    if (state == S_HDR) begin
      mem_addr_o = base;
    end else if (state == S_REQ) begin
      mem_addr_o = base + BW_MEM_ADDR'(4) + (BW_MEM_ADDR'({sel, idx}) << 2);
    end
  end

  assign busy_o           = (state != S_IDLE);
  assign done_o           = (state == S_DONE);
  assign mem_req_o        = (state == S_HDR) || (state == S_REQ);
  assign tbl_wren_o       = (state == S_WR);
  assign tbl_addr_o       = {sel, idx};
  assign tbl_data_o       = data_q;
  assign tbl_phase_refs_o = phase_refs;

endmodule

// File: tb/tb_lease_table_loader.sv
// Bench for lease_table_loader with N_ENTRIES = 4. A behavioural memory
// answers requests after a programmable number of wait cycles. Expected read
// addresses and table writes are queued when a load is started and are
// consumed as the DUT produces them.
module tb_lease_table_loader;

  localparam int N  = 4;
  localparam int BW = 2;
`ifdef LEASE_LOADER_SPARSE_FETCH_EN
  localparam bit SPARSE = 1'b1;
`else
  localparam bit SPARSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [31:0]   base_addr_i;
  logic          busy_o, done_o, mem_req_o, mem_ack_i, tbl_wren_o;
  logic [31:0]   mem_addr_o, mem_data_i, tbl_data_o;
  logic [BW:0]   tbl_addr_o;
  logic [BW-1:0] tbl_phase_refs_o;

  lease_table_loader #(.N_ENTRIES(N), .BW_MEM_ADDR(32)) dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .tbl_addr_o(tbl_addr_o),
    .tbl_wren_o(tbl_wren_o), .tbl_data_o(tbl_data_o), .tbl_phase_refs_o(tbl_phase_refs_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  typedef struct {
    logic [BW:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          exp_done;
  int          exp_refs;

  // Memory model
  int          mem_wait = 0;
  logic [31:0] mem_hdr  = '0;
  logic [31:0] mem_r    = '0;
  bit          waiting  = 1'b0;
  logic [31:0] held;
  int          wcnt;

  always @(negedge clk) begin
    if (reset_i || !mem_req_o) begin
      mem_ack_i = 1'b0;
      waiting   = 1'b0;
    end else begin
      if (!waiting) begin
        waiting = 1'b1;
        held    = mem_addr_o;
        wcnt    = 0;
      end else begin
        chk("addr_stable", mem_addr_o, held);
      end
      if (wcnt == mem_wait) begin
        mem_ack_i  = 1'b1;
        mem_data_i = (mem_addr_o == mem_hdr) ? mem_r : pat(mem_addr_o);
        waiting    = 1'b0;
        if (rd_q.size() == 0) begin
          chk("extra_read", mem_addr_o, 32'hFFFF_FFFF);
        end else begin
          chk("read_addr", mem_addr_o, rd_q.pop_front());
        end
      end else begin
        mem_ack_i = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic prep(input int r, input int w, input logic [31:0] base);
    int fetched, skipped;
    logic [31:0] a;
    wr_q.delete();
    rd_q.delete();
    exp_refs = (r >= N - 1) ? N - 1 : r;
    mem_wait = w;
    mem_hdr  = {base[31:2], 2'b00};
    mem_r    = r;
    rd_q.push_back(mem_hdr);
    fetched = 0;
    skipped = 0;
    for (int i = 0; i < 2 * N; i++) begin
      bit is_lease = (i >= N);
      int ix = i % N;
      a = mem_hdr + 4 + 4 * i;
      if (!SPARSE || ix < exp_refs) begin
        rd_q.push_back(a);
        wr_q.push_back('{addr: i[BW:0], data: pat(a)});
        fetched++;
      end else if (!is_lease) begin
        wr_q.push_back('{addr: i[BW:0], data: 32'h0});
        skipped++;
      end
    end
    exp_done = 2 + w + fetched * (2 + w) + skipped;
  endtask

  task automatic run_load(input int r, input int w, input logic [31:0] base, input int restart_at);
    int  s;
    bit  first_wr, got_done;
    int  extra_done;
    wr_t e;
    prep(r, w, base);
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = base;
    s           = cyc;
    first_wr    = 1'b1;
    got_done    = 1'b0;
    for (int k = 1; k < 2000 && !got_done; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (k == restart_at) begin
        start_i     = 1'b1;
        base_addr_i = 32'hDEAD_0000;
      end
      if (k == 1) chk("busy_hdr", busy_o, 1'b1);
      if (tbl_wren_o) begin
        if (first_wr) begin
          chk("refs_before_wr", tbl_phase_refs_o, exp_refs);
          first_wr = 1'b0;
        end
        if (wr_q.size() == 0) begin
          chk("extra_write", tbl_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", tbl_addr_o, e.addr);
          chk("wr_data", tbl_data_o, e.data);
        end
      end
      if (done_o) begin
        chk("done_cycle", cyc - s, exp_done);
        got_done = 1'b1;
      end
    end
    start_i = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("reads_left", rd_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
    chk("refs_final", tbl_phase_refs_o, exp_refs);
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_o) extra_done++;
    end
    chk("extra_done", extra_done, 0);
    chk("busy_after", busy_o, 1'b0);
  endtask

  typedef struct {
    int          r;
    int          w;
    logic [31:0] base;
    int          restart_at;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{r: 2,   w: 0, base: 32'h0000_0100, restart_at: -1};
    vecs[1] = '{r: 2,   w: 3, base: 32'h0000_0100, restart_at: -1};
    vecs[2] = '{r: 100, w: 0, base: 32'h0000_2003, restart_at: -1};
    vecs[3] = '{r: 0,   w: 1, base: 32'h0000_0040, restart_at: -1};
    vecs[4] = '{r: 3,   w: 2, base: 32'h0001_0082, restart_at: -1};
    vecs[5] = '{r: 2,   w: 0, base: 32'h0000_0300, restart_at: 5};

    reset_i     = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    mem_ack_i   = 1'b0;
    mem_data_i  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    chk("rst_wren", tbl_wren_o, 1'b0);
    chk("rst_taddr", tbl_addr_o, 0);
    chk("rst_tdata", tbl_data_o, 32'h0);
    chk("rst_refs", tbl_phase_refs_o, 0);
    reset_i = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_load(vecs[v].r, vecs[v].w, vecs[v].base, vecs[v].restart_at);
    end

    // Reset while a lease word is being requested.
    begin
      bit hit = 1'b0;
      prep(2, 2, 32'h0000_0500);
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = 32'h0000_0500;
      for (int k = 0; k < 500 && !hit; k++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (mem_req_o && tbl_addr_o[BW]) hit = 1'b1;
      end
      chk("lease_req_seen", hit, 1'b1);
      chk("refs_pre_reset", tbl_phase_refs_o, 2);
      reset_i = 1'b1;
      #1;
      chk("abort_req", mem_req_o, 1'b0);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_refs", tbl_phase_refs_o, 0);
      @(negedge clk);
      reset_i = 1'b0;
      run_load(2, 0, 32'h0000_0500, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
